// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with a restoring divider and hi/lo write-back.
module muldiv_ctrl #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [W-1:0]     a_q, b_q;
  logic [W-1:0]     d_q, r_q, q_q;
  logic             qneg_q, rneg_q, dz_q;
  logic [W-1:0]     res_hi_q, res_lo_q;

  logic [2*W-1:0]   prod;
  logic [W:0]       r_sh;
  logic [W+1:0]     diff;
  logic [W-1:0]     r_nx, q_nx;

  // Two's-complement negate, truncated to 32 bits.
  function automatic logic [W-1:0] neg32(input logic [W-1:0] x);
    return ~x + W'(1);
  endfunction

  // Product of the latched operands; signed for MULT, unsigned for MULTU.
  always_comb begin
    if (!op_q[0]) prod = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};
    else          prod = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    r_sh = {r_q, q_q[W-1]};
    diff = {1'b0, r_sh} - {2'b00, d_q};
    if (!diff[W+1]) begin
      r_nx = diff[W-1:0];
      q_nx = {q_q[W-2:0], 1'b1};
    end else begin
      r_nx = r_sh[W-1:0];
      q_nx = {q_q[W-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and outputs; flush wins over start, busy stalls from the accepting cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    hilo_we = 1'b0;
    hi_out  = '0;
    lo_out  = '0;
    case (state_q)
      IDLE: begin
        accept = start & ~flush & ~reset;
        busy   = accept;
        if (accept) state_d = op[1] ? DIV : MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (flush)              state_d = IDLE;
        else if (cnt_q == '0)   state_d = DONE;
      end
      DIV: begin
        busy = 1'b1;
        if (flush)              state_d = IDLE;
        else if (cnt_q == '0)   state_d = DONE;
      end
      DONE: begin
        hilo_we = ~flush;
        done    = ~flush;
        if (!flush) begin
          hi_out = res_hi_q;
          lo_out = res_lo_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, cycle counter and mult/div datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      q_q      <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q   <= op;
            a_q    <= a;
            b_q    <= b;
            r_q    <= '0;
            dz_q   <= (b == '0);
            qneg_q <= ~op[0] & (a[W-1] ^ b[W-1]);
            rneg_q <= ~op[0] & a[W-1];
            q_q    <= (~op[0] & a[W-1]) ? neg32(a) : a;
            d_q    <= (~op[0] & b[W-1]) ? neg32(b) : b;
            cnt_q  <= op[1] ? CNT_W'(W - 1) : CNT_W'(MUL_CYCLES - 1);
          end
        end
        MUL: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
          res_hi_q <= prod[2*W-1:W];
          res_lo_q <= prod[W-1:0];
        end
        DIV: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
          r_q <= r_nx;
          q_q <= q_nx;
          if (cnt_q == '0) begin
            // Divide by zero keeps the dividend in hi and saturates lo.
            res_lo_q <= dz_q ? '1  : (qneg_q ? neg32(q_nx) : q_nx);
            res_hi_q <= dz_q ? a_q : (rneg_q ? neg32(r_nx) : r_nx);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected hi/lo queued at issue, popped on each hilo_we.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, hilo_we;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [63:0] exp_q[$];

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;

  muldiv_ctrl #(.MUL_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hilo_we(hilo_we), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  // Result monitor: every write-back must match the oldest queued expectation.
  always @(negedge clk) begin
    if (hilo_we === 1'b1) begin
      logic [63:0] e;
      we_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_hilo_we hi=%h lo=%h", hi_out, lo_out);
      end else begin
        e = exp_q.pop_front();
        if ({hi_out, lo_out} !== e) begin
          errors++;
          $display("FAIL result got hi=%h lo=%h exp hi=%h lo=%h", hi_out, lo_out, e[63:32], e[31:0]);
        end
      end
    end else if (reset === 1'b0) begin
      checks++;
      if (hi_out !== 32'h0 || lo_out !== 32'h0) begin
        errors++;
        $display("FAIL idle_result_zero got hi=%h lo=%h exp 0", hi_out, lo_out);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue an op in the current cycle and walk it to DONE, checking busy/done timing.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] e, input int lat, input bit hold);
    start = 1'b1; op = o; a = x; b = y;
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s accept_busy got %b exp 1", tag, busy); end
    exp_q.push_back(e);
    for (int c = 1; c <= lat; c++) begin
      step();
      if (!hold) begin
        start = 1'b0;
        a = $urandom;
        b = $urandom;
      end
      #1;
      checks++;
      if (c < lat) begin
        if (busy !== 1'b1 || hilo_we !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s cyc%0d busy/we/done got %b%b%b exp 100", tag, c, busy, hilo_we, done);
        end
      end else begin
        if (busy !== 1'b0 || hilo_we !== 1'b1 || done !== 1'b1) begin
          errors++;
          $display("FAIL %s done_cyc busy/we/done got %b%b%b exp 011", tag, busy, hilo_we, done);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; flush = 1'b0; op = 2'd0; a = 32'd5; b = 32'd6;
    step(); step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hilo_we !== 1'b0 || hi_out !== 32'h0 || lo_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b we=%b hi=%h lo=%h exp all 0", busy, done, hilo_we, hi_out, lo_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, MUL_LAT, 1'b0);
    step();
    run_op("mult_neg", 2'd0, 32'd3, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'hFFFFFFFA}, MUL_LAT, 1'b0);
    step();
    run_op("mult_min", 2'd0, 32'h80000000, 32'h80000000, {32'h40000000, 32'h00000000}, MUL_LAT, 1'b0);
    step();
  endtask

  task automatic test_div();
    run_op("div_neg7_2", 2'd2, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, DIV_LAT, 1'b0);
    step();
    run_op("divu_by0", 2'd3, 32'h64, 32'h0, {32'h00000064, 32'hFFFFFFFF}, DIV_LAT, 1'b0);
    step();
    run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, DIV_LAT, 1'b0);
    step();
    run_op("div_7_neg2", 2'd2, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, DIV_LAT, 1'b0);
    step();
    run_op("div_neg_by0", 2'd2, 32'hFFFFFFF9, 32'h0, {32'hFFFFFFF9, 32'hFFFFFFFF}, DIV_LAT, 1'b0);
    step();
    run_op("divu_big", 2'd3, 32'hFFFFFFFF, 32'h10, {32'h0000000F, 32'h0FFFFFFF}, DIV_LAT, 1'b0);
    step();
  endtask

  task automatic test_flush();
    int we0;
    we0 = we_cnt;
    // Squash a divide in flight, then issue a multiply the next cycle.
    start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      step();
      start = 1'b0;
    end
    flush = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || hilo_we !== 1'b0) begin
      errors++; $display("FAIL flush_cyc10 busy/we got %b%b exp 10", busy, hilo_we);
    end
    step();
    flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hilo_we !== 1'b0) begin
      errors++; $display("FAIL flush_cyc11 busy/we got %b%b exp 00", busy, hilo_we);
    end
    run_op("mult_after_flush", 2'd0, 32'd3, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'hFFFFFFFA}, MUL_LAT, 1'b0);
    step();
    // Flush in DONE suppresses the write-back.
    start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd3;
    step(); start = 1'b0;
    step(); step();
    flush = 1'b1;
    #1;
    checks++;
    if (hilo_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_in_done we/done/busy got %b%b%b exp 000", hilo_we, done, busy);
    end
    step();
    // Simultaneous start and flush in IDLE: nothing accepted.
    start = 1'b1; flush = 1'b1; op = 2'd0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_flush_idle busy got %b exp 0", busy); end
    step();
    start = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_flush_not_taken busy got %b exp 0", busy); end
    step(); step();
    checks++;
    if (we_cnt != we0 + 1) begin
      errors++; $display("FAIL flush_we_count got %0d exp %0d", we_cnt - we0, 1);
    end
  endtask

  task automatic test_back_to_back();
    int we0;
    we0 = we_cnt;
    run_op("divu_hold1", 2'd3, 32'd9, 32'd4, {32'd1, 32'd2}, DIV_LAT, 1'b1);
    step();
    checks++;
    if (we_cnt != we0 + 1) begin
      errors++; $display("FAIL hold_single_pulse got %0d exp 1", we_cnt - we0);
    end
    run_op("divu_hold2", 2'd3, 32'd9, 32'd4, {32'd1, 32'd2}, DIV_LAT, 1'b0);
    step();
  endtask

  task automatic test_reset_mid();
    int we0;
    we0 = we_cnt;
    start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
    for (int c = 1; c <= 5; c++) begin
      step();
      start = 1'b0;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hilo_we !== 1'b0 || hi_out !== 32'h0 || lo_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs got busy=%b done=%b we=%b hi=%h lo=%h exp all 0", busy, done, hilo_we, hi_out, lo_out);
    end
    repeat (40) step();
    checks++;
    if (we_cnt != we0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_no_we got we=%0d busy=%b exp 0 0", we_cnt - we0, busy);
    end
    run_op("mult_after_reset", 2'd1, 32'd7, 32'd6, {32'd0, 32'd42}, MUL_LAT, 1'b0);
    step();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 2: number of MUL-state cycles, legal range 1..4.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: a mult/div instruction is valid in the execute stage.
REQ-005 SHALL have port op, input, 2 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 SHALL have ports a and b, input, 32 bits each: operands (rs, rt); b is the divisor.
REQ-007 SHALL have port flush, input, 1 bit: squash the in-flight operation (exception or eret).
REQ-008 SHALL have port busy, output, 1 bit: stall request to the hazard unit.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port hilo_we, output, 1 bit: write enable to the hilo register.
REQ-011 SHALL have ports hi_out and lo_out, output, 32 bits each: result; valid only while hilo_we=1.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV and DONE.
REQ-013 In IDLE, start=1 with flush=0 SHALL accept the operation ("cycle 0").
- Latch op, a and b.
- For a divide, also latch |a|, |b| and the sign bits.
- Go to MUL (op 0/1) or DIV (op 2/3).
REQ-014 busy SHALL equal (state==MUL or state==DIV) or (state==IDLE and start and not flush); busy is combinational so the accepting cycle already stalls.
REQ-015 MUL SHALL last MUL_CYCLES cycles (down-counter), then enter DONE.
- The 64-bit product is registered: signed for MULT, unsigned for MULTU.
- With the default, DONE falls in cycle 3.
REQ-016 DIV SHALL perform restoring division, one quotient bit per cycle, for exactly 32 cycles (6-bit counter 31..0), then enter DONE; DONE falls in cycle 33.
REQ-017 Divide sign rules SHALL be:
- DIV quotient sign = a[31] xor b[31].
- DIV remainder sign = a[31].
- Negation is two's complement, truncated to 32 bits.
- 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0.
REQ-018 A divide by zero (b==0, DIV or DIVU) SHALL take the same 34 cycles and yield lo=0xFFFFFFFF, hi=a unchanged.
REQ-019 In DONE:
- hilo_we = done = not flush.
- busy = 0.
- hi_out/lo_out = result (hi = product[63:32] or remainder; lo = product[31:0] or quotient).
- Next state is always IDLE.
REQ-020 start SHALL be ignored in MUL, DIV and DONE; the stalled instruction still asserting start in DONE SHALL NOT be re-accepted.
REQ-021 flush SHALL have priority over start in every state.
- flush in any state → next state IDLE; no hilo_we for the squashed operation.
- Simultaneous start and flush in IDLE → nothing accepted, busy=0.
REQ-022 Outside DONE, hilo_we and done SHALL be 0; hi_out/lo_out SHALL be 0 when hilo_we=0.
REQ-023 A back-to-back operation SHALL be accepted at the earliest in the cycle after DONE.
REQ-024 Operand changes after the accepting cycle SHALL NOT affect the result.

Reset
REQ-025 reset=1 SHALL force, at the next rising edge:
- state IDLE and counters 0;
- busy=0, done=0, hilo_we=0, hi_out=0, lo_out=0.
REQ-026 reset SHALL override start and flush; reset mid-operation SHALL abandon it with no hilo_we.
REQ-027 After reset deasserts, start SHALL be accepted in the first cycle.

Verification
REQ-028 MULTU a=0xFFFFFFFF b=0xFFFFFFFF → busy cycles 0-2; cycle 3 hilo_we=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 DIV a=0xFFFFFFF9 (-7) b=2 → busy cycles 0-32; cycle 33 lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-030 DIVU a=0x64 b=0 → cycle 33 lo=0xFFFFFFFF, hi=0x64; then DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
REQ-031 DIV started, flush at cycle 10 → cycle 11 busy=0 with no hilo_we ever; a new MULT 3×-2 accepted at cycle 11 → lo=0xFFFFFFFA, hi=0xFFFFFFFF at cycle 14.
REQ-032 start held high across a full DIVU 9/4 → exactly one hilo_we pulse (lo=2, hi=1); start still high the cycle after DONE → accepted again.
REQ-033 reset at cycle 5 of a DIV → next cycle all outputs 0, state IDLE; no hilo_we observed.
